// File: rtl/btn_debounce_pkg.sv
// btn_pkg: definitions shared by the button debouncer and anything that
// probes it.
//
// Contents:
//   btn_state_t : the 2-bit debouncer state encoding. The values are fixed
//                 so that benches and debug logic can decode the state
//                 register directly.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage : btn_pkg

// File: rtl/btn_debounce_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous board input.
// It is reusable for any slow board-level signal.
//
// Ports:
//   Clk : destination clock
//   Rst : synchronous active-high reset; both flops clear to 0
//   d   : asynchronous input
//   q   : synchronized copy of d, delayed by two Clk edges
module sync2 (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule : sync2

// File: rtl/btn_debounce.sv
// btn_debounce: turns a raw push-button line into clean synchronous
// controls. It provides a debounced level, one-cycle press and release
// strobes, and a long-press indication.
//
// Parameters:
//   DB_BITS   : the input must be stable for 2^DB_BITS cycles before a
//               change of level is accepted
//   LONG_BITS : the long press fires after 2^LONG_BITS further cycles held
//
// Ports:
//   Clk          : single clock
//   Rst          : synchronous active-high reset
//   BtnIn        : raw asynchronous active-high button
//   Level        : debounced button state
//   PressPulse   : one-cycle strobe on an accepted press
//   ReleasePulse : one-cycle strobe on an accepted release
//   LongPulse    : one-cycle strobe when the long-press threshold is reached
//   LongHeld     : high from LongPulse until the accepted release
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_BITS   = 20,
    parameter int LONG_BITS = 24
) (
    input  logic Clk,
    input  logic Rst,
    input  logic BtnIn,
    output logic Level,
    output logic PressPulse,
    output logic ReleasePulse,
    output logic LongPulse,
    output logic LongHeld
);

    logic                 s;
    btn_state_t           state_reg;
    logic [DB_BITS-1:0]   db_cnt_reg;
    logic [LONG_BITS-1:0] long_cnt_reg;

    sync2 u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (BtnIn),
        .q   (s)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            // A reset during a press intentionally produces no release strobe.
            state_reg    <= IDLE;
            db_cnt_reg   <= '0;
            long_cnt_reg <= '0;
            Level        <= 1'b0;
            PressPulse   <= 1'b0;
            ReleasePulse <= 1'b0;
            LongPulse    <= 1'b0;
            LongHeld     <= 1'b0;
        end else begin
            PressPulse   <= 1'b0;
            ReleasePulse <= 1'b0;
            LongPulse    <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (s) begin
                        state_reg  <= PRESS_WAIT;
                        db_cnt_reg <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!s) begin
                        state_reg <= IDLE;
                    end else if (&db_cnt_reg) begin
                        state_reg    <= PRESSED;
                        Level        <= 1'b1;
                        PressPulse   <= 1'b1;
                        long_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end

                PRESSED: begin
                    // A release takes priority over the long threshold. The
                    // long counter keeps its value so that a bounce-rejected
                    // release resumes the count instead of restarting it.
                    if (!s) begin
                        state_reg  <= RELEASE_WAIT;
                        db_cnt_reg <= '0;
                    end else if (&long_cnt_reg) begin
                        // The counter saturates here. LongHeld makes the
                        // strobe fire only once per press.
                        if (!LongHeld) begin
                            LongPulse <= 1'b1;
                            LongHeld  <= 1'b1;
                        end
                    end else begin
                        long_cnt_reg <= long_cnt_reg + 1'b1;
                    end
                end

                RELEASE_WAIT: begin
                    if (s) begin
                        state_reg <= PRESSED;
                    end else if (&db_cnt_reg) begin
                        state_reg    <= IDLE;
                        Level        <= 1'b0;
                        ReleasePulse <= 1'b1;
                        LongHeld     <= 1'b0;
                        long_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_BITS=2 and LONG_BITS=3.
// The stimulus queues each expected strobe with its hand-computed edge
// number. A monitor compares every strobe the DUT raises against the head
// of that queue.
module tb_btn_debounce;
    import btn_pkg::*;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int   kind;
        int   edge_no;
        logic level;
        logic held;
    } ev_t;

    logic clk = 1'b0;
    logic Rst;
    logic BtnIn;
    logic Level, PressPulse, ReleasePulse, LongPulse, LongHeld;

    int   edge_n  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  exp_q[$];

    btn_debounce #(
        .DB_BITS   (2),
        .LONG_BITS (3)
    ) dut (
        .Clk          (clk),
        .Rst          (Rst),
        .BtnIn        (BtnIn),
        .Level        (Level),
        .PressPulse   (PressPulse),
        .ReleasePulse (ReleasePulse),
        .LongPulse    (LongPulse),
        .LongHeld     (LongHeld)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input int kind, input int e, input logic lvl, input logic held);
        ev_t ev;
        ev.kind    = kind;
        ev.edge_no = e;
        ev.level   = lvl;
        ev.held    = held;
        exp_q.push_back(ev);
    endtask

    task automatic check_ev(input int kind);
        ev_t ev;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got kind=%0d at edge %0d, required no pulse", kind, edge_n);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != kind || ev.edge_no != edge_n || Level !== ev.level || LongHeld !== ev.held) begin
                n_fail++;
                $display("FAIL pulse_event: got kind=%0d edge=%0d level=%b held=%b, required kind=%0d edge=%0d level=%b held=%b",
                         kind, edge_n, Level, LongHeld, ev.kind, ev.edge_no, ev.level, ev.held);
            end else begin
                $display("[TB] pulse kind=%0d at edge %0d level=%b held=%b ok", kind, edge_n, Level, LongHeld);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, req, edge_n);
        end else begin
            $display("[TB] check %s = 0x%0h at edge %0d ok", name, act, edge_n);
        end
    endtask

    // Return at the first falling edge at which edge e has occurred.
    task automatic at(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Monitor: every strobe the DUT raises is one transaction.
    always @(negedge clk) begin
        if (PressPulse)   check_ev(K_PRESS);
        if (ReleasePulse) check_ev(K_RELEASE);
        if (LongPulse)    check_ev(K_LONG);
    end

    initial begin
        int t;
        logic [4:0] pat;

        // Reset held for two cycles with the button already pressed.
        Rst   = 1'b1;
        BtnIn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {3'b0, Level, PressPulse, ReleasePulse, LongPulse, LongHeld}, 8'h00);
        chk("reset_state", 8'(dut.state_reg), 8'(IDLE));

        // A button held through reset needs a fresh press: 7 edges. It then
        // continues into a long press, whose strobe comes 8 edges after the
        // Level rise.
        t   = edge_n;
        Rst = 1'b0;
        expect_ev(K_PRESS, t + 7, 1'b1, 1'b0);
        expect_ev(K_LONG,  t + 15, 1'b1, 1'b1);
        at(t + 14);
        chk("held_before_long", {7'b0, LongHeld}, 8'h00);
        at(t + 16);
        chk("held_after_long", {7'b0, LongHeld}, 8'h01);
        t     = edge_n;
        BtnIn = 1'b0;
        expect_ev(K_RELEASE, t + 7, 1'b0, 1'b0);
        at(t + 6);
        chk("held_until_release", {6'b0, Level, LongHeld}, 8'h03);
        at(t + 10);

        // Bounce on press: 1,0,1,1,0 then a steady 1.
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            BtnIn = pat[i];
            @(negedge clk);
        end
        t     = edge_n;
        BtnIn = 1'b1;
        expect_ev(K_PRESS, t + 7, 1'b1, 1'b0);
        at(t + 6);
        chk("bounce_level_low", {7'b0, Level}, 8'h00);
        at(t + 7);
        t     = edge_n;
        BtnIn = 1'b0;
        expect_ev(K_RELEASE, t + 7, 1'b0, 1'b0);
        at(t + 10);

        // Short press: 10 cycles high. There is no long strobe.
        t     = edge_n;
        BtnIn = 1'b1;
        expect_ev(K_PRESS, t + 7, 1'b1, 1'b0);
        at(t + 10);
        BtnIn = 1'b0;
        expect_ev(K_RELEASE, t + 17, 1'b0, 1'b0);
        at(t + 16);
        chk("short_level_before_fall", {7'b0, Level}, 8'h01);
        at(t + 20);

        // Release bounce: two cycles low while PRESSED. The long counter
        // pauses for three edges, so the strobe moves from t+15 to t+18.
        t     = edge_n;
        BtnIn = 1'b1;
        expect_ev(K_PRESS, t + 7, 1'b1, 1'b0);
        at(t + 9);
        BtnIn = 1'b0;
        at(t + 11);
        BtnIn = 1'b1;
        expect_ev(K_LONG, t + 18, 1'b1, 1'b1);
        at(t + 13);
        chk("rel_bounce_level", {7'b0, Level}, 8'h01);
        at(t + 15);
        chk("rel_bounce_no_long_yet", {6'b0, Level, LongHeld}, 8'h02);

        // Reset mid-press: everything clears on the next edge, with no release strobe.
        at(t + 20);
        chk("pre_reset_pressed", {6'b0, Level, LongHeld}, 8'h03);
        Rst = 1'b1;
        @(negedge clk);
        chk("midpress_reset_outputs", {3'b0, Level, PressPulse, ReleasePulse, LongPulse, LongHeld}, 8'h00);
        chk("midpress_reset_state", 8'(dut.state_reg), 8'(IDLE));
        t   = edge_n;
        Rst = 1'b0;
        expect_ev(K_PRESS, t + 7, 1'b1, 1'b0);
        at(t + 7);
        t     = edge_n;
        BtnIn = 1'b0;
        expect_ev(K_RELEASE, t + 7, 1'b0, 1'b0);

        // Drain: every queued strobe must have been seen within the bound.
        at(t + 15);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_btn_debounce
